// File: rtl/fifo_arb_pkg.sv
// Purpose: shared types and default sizing for the FIFO write-side arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: arb_state_t FSM encoding, default requester count, word width and burst cap.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int ARB_NREQ     = 4;
   localparam int ARB_DSIZE    = 8;
   localparam int ARB_MAXBURST = 8;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Purpose: round-robin selector, first set request at or after ptr (mod NREQ).
// Latency: purely combinational.
// Backpressure: none; evaluates every cycle.
// Ports: req (request vector), ptr (search start index), pick (one-hot winner),
//        found (any request set).
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = ARB_NREQ,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] pick,
   output logic            found
);

   logic [PW-1:0] idx;

   // Walk NREQ positions starting at ptr; the first hit wins and masks the rest.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = PW'((int'(ptr) + k) % NREQ);
         if (!found && req[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Purpose: round-robin burst arbiter muxing NREQ write requesters onto one FIFO write port.
// Latency: grant 1 cycle after request seen in IDLE; data path is combinational (no stage).
// Backpressure: wfull stalls the granted requester via req_ready; grant and beat count hold.
// Ports: wclk/wrst (clock, sync active-high reset); req_valid/req_data/req_last/req_ready
//        (per-requester handshake); wfull/winc/wdata (FIFO write side); gnt/busy (status).
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ     = ARB_NREQ,
   parameter int DSIZE    = ARB_DSIZE,
   parameter int MAXBURST = ARB_MAXBURST
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*DSIZE-1:0] req_data,
   input  logic [NREQ-1:0]       req_last,
   output logic [NREQ-1:0]       req_ready,
   input  logic                  wfull,
   output logic                  winc,
   output logic [DSIZE-1:0]      wdata,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int BW = $clog2(MAXBURST + 1);

   arb_state_t      state_q, state_nxt;
   logic [NREQ-1:0] gnt_q;
   logic [PW-1:0]   rr_ptr_q;
   logic [BW-1:0]   beat_q;

   logic [NREQ-1:0] pick;
   logic            found;
   logic [PW-1:0]   pick_idx;
   logic [PW-1:0]   next_ptr;
   logic [BW-1:0]   beat_nxt;
   logic            xfer;
   logic            burst_end;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_pick (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .pick  (pick),
      .found (found)
   );

   // Binary index of the winner so the pointer can move one past it.
   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick[i]) pick_idx = PW'(i);
      end
      next_ptr = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
   end

   // State and grant bookkeeping.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         rr_ptr_q <= '0;
         beat_q   <= '0;
      end else begin
         state_q <= state_nxt;
         if (state_q == IDLE) begin
            if (found) begin
               gnt_q    <= pick;
               rr_ptr_q <= next_ptr;
               beat_q   <= '0;
            end
         end else if (burst_end) begin
            gnt_q  <= '0;
            beat_q <= '0;
         end else if (xfer) begin
            beat_q <= beat_nxt;
         end
      end
   end

   // Next-state: a burst is locked until its last beat or the beat cap.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (found)     state_nxt = BURST;
         BURST:   if (burst_end) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Outputs. Everything that can move a word is also gated by wrst so nothing
   // leaks out during the reset cycle even if a grant is still registered.
   always_comb begin
      busy      = (state_q == BURST);
      gnt       = gnt_q;
      req_ready = (busy && !wrst && !wfull) ? gnt_q : '0;
      xfer      = busy && !wrst && !wfull && (|(req_valid & gnt_q));
      winc      = xfer;
      wdata     = '0;
      if (!wrst) begin
         for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) wdata = req_data[i*DSIZE +: DSIZE];
         end
      end
      beat_nxt  = beat_q + 1'b1;
      burst_end = xfer && ((|(req_last & gnt_q)) || (beat_nxt == BW'(MAXBURST)));
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of write requesters.
REQ-002 Parameter DSIZE, default 8: data word width.
REQ-003 Parameter MAXBURST, default 8: maximum beats per grant.
REQ-004 wclk  input  1  single clock; all logic on rising edge.
REQ-005 wrst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NREQ  per-requester word valid.
REQ-007 req_data  input  NREQ*DSIZE  per-requester word; requester i occupies bits [i*DSIZE +: DSIZE].
REQ-008 req_last  input  NREQ  marks final word of requester's burst.
REQ-009 req_ready  output  NREQ  word accepted when req_valid[i] & req_ready[i].
REQ-010 wfull  input  1  full flag from the FIFO write side.
REQ-011 winc  output  1  FIFO write strobe.
REQ-012 wdata  output  DSIZE  FIFO write data.
REQ-013 gnt  output  NREQ  one-hot registered grant; all-zero when idle.
REQ-014 busy  output  1  high while a burst grant is held.

Function
REQ-015 States: IDLE, BURST.
REQ-016 IDLE: if any req_valid high, select first index at or after rr_ptr (mod NREQ) with req_valid high; next cycle gnt = one-hot of it, state = BURST, rr_ptr = (index+1) mod NREQ.
REQ-017 Grant latency: gnt asserts exactly 1 cycle after req_valid is sampled in IDLE; no word transfers in IDLE.
REQ-018 BURST, granted index g: req_ready[g] = ~wfull, all other req_ready = 0, combinational.
REQ-019 winc = req_valid[g] & ~wfull; wdata = req_data[g]; same cycle, combinational; wdata = 0 when no grant.
REQ-020 Transfer = winc high; beat counter (width clog2(MAXBURST+1)) increments on each transfer, cleared on entering BURST.
REQ-021 Burst ends on the transfer carrying req_last[g], or the transfer making the beat count equal MAXBURST, whichever first; next cycle state = IDLE, gnt = 0, counter = 0.
REQ-022 wfull high: no transfer, counter and grant hold; no word dropped or duplicated.
REQ-023 Granted requester deasserting req_valid mid-burst: grant held (burst lock), no timeout.
REQ-024 Non-granted requesters never see req_ready high; their valid/data ignored.
REQ-025 Each burst costs one IDLE bubble cycle before the next grant.
REQ-026 Single requester continuously valid: repeatedly regranted, one bubble between bursts.

Reset
REQ-027 wrst high at a rising edge: state = IDLE, gnt = 0, rr_ptr = 0, counter = 0, busy = 0.
REQ-028 During and after reset, until the first grant: winc = 0, req_ready = 0, wdata = 0.
REQ-029 Reset mid-burst aborts the burst; the partial burst is not resumed; arbitration restarts from index 0.

Structure
REQ-030 Shared package fifo_arb_pkg: state enum {IDLE, BURST}, default NREQ/DSIZE/MAXBURST constants.
REQ-031 Combinational sub-module rr_pick: inputs req vector and rr_ptr, outputs one-hot pick and found flag; only sub-module.
REQ-032 No storage of data words; arbiter adds no pipeline stage in the data path.

Verification
REQ-033 wrst high 2 cycles with req_valid=4'b1111 -> gnt=0, winc=0, req_ready=0 throughout; first grant gnt=4'b0001 one cycle after wrst falls.
REQ-034 Requesters 0 and 2 valid, 3-word bursts, last on 3rd beat -> gnt 0001 for 3 transfers, 1 bubble, gnt 0100 for 3 transfers; winc count = 6.
REQ-035 Requester 1 valid continuously, req_last never high, MAXBURST=8 -> exactly 8 transfers, gnt=0, then regranted 0010 after 1 bubble.
REQ-036 wfull high 5 cycles mid-burst after beat 2 -> winc=0 and req_ready[g]=0 for those 5 cycles, beat 3 data delivered once when wfull falls.
REQ-037 All 4 valid, 1-word bursts -> grant order 0,1,2,3,0 (wrap-around of rr_ptr).
REQ-038 wrst asserted after beat 2 of requester 3's burst -> next grant is requester 0, counter restarts at 0.
